// File: rtl/execute_unit.sv
// Y86 execute stage: ALU, condition codes, branch/cmov condition, valid/ready handshake.
// Optional iterative multiplier for OPq ifun 4 is enabled by defining EXECUTE_UNIT_MUL_EN.
module execute_unit #(
    parameter int WIDTH      = 64,
    parameter int STACK_STEP = WIDTH / 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       icode,
    input  logic [3:0]       ifun,
    input  logic [WIDTH-1:0] valA,
    input  logic [WIDTH-1:0] valB,
    input  logic [WIDTH-1:0] valC,
    input  logic [3:0]       dstE_in,
    input  logic             cc_block,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] valE,
    output logic [WIDTH-1:0] valA_out,
    output logic [3:0]       dstE_out,
    output logic             Cnd,
    output logic [2:0]       cc,
    output logic             err
);

    localparam logic [3:0] I_RRMOV = 4'h2;
    localparam logic [3:0] I_IRMOV = 4'h3;
    localparam logic [3:0] I_RMMOV = 4'h4;
    localparam logic [3:0] I_MRMOV = 4'h5;
    localparam logic [3:0] I_OPQ   = 4'h6;
    localparam logic [3:0] I_JXX   = 4'h7;
    localparam logic [3:0] I_CALL  = 4'h8;
    localparam logic [3:0] I_RET   = 4'h9;
    localparam logic [3:0] I_PUSH  = 4'hA;
    localparam logic [3:0] I_POP   = 4'hB;
    localparam logic [WIDTH-1:0] STEP = WIDTH'(STACK_STEP);

    // cc layout is {ZF,SF,OF}
    function automatic logic cond_eval(input logic [3:0] fn, input logic [2:0] c);
        logic lt;
        lt = c[1] ^ c[0];
        case (fn)
            4'd0:    return 1'b1;
            4'd1:    return lt | c[2];
            4'd2:    return lt;
            4'd3:    return c[2];
            4'd4:    return !c[2];
            4'd5:    return !lt;
            4'd6:    return !lt && !c[2];
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [WIDTH:0] alu_op(input logic [1:0] fn,
                                              input logic signed [WIDTH-1:0] a,
                                              input logic signed [WIDTH-1:0] b);
        logic signed [WIDTH-1:0] r;
        logic                    of;
        of = 1'b0;
        case (fn)
            2'd0: begin
                r  = b + a;
                of = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != b[WIDTH-1]);
            end
            2'd1: begin
                r  = b - a;
                of = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != b[WIDTH-1]);
            end
            2'd2:    r = b & a;
            default: r = b ^ a;
        endcase
        return {of, r};
    endfunction

    logic             out_valid_q, cnd_q, err_q;
    logic [WIDTH-1:0] valE_q, valA_out_q;
    logic [3:0]       dstE_q;
    logic [2:0]       cc_q;

    logic             cnd_d, err_d, cc_we, mul_go, accept, idle;
    logic [WIDTH-1:0] valE_d;
    logic [3:0]       dst_d;
    logic [2:0]       cc_new;
    logic [WIDTH:0]   alu_r;

`ifdef EXECUTE_UNIT_MUL_EN
    typedef enum logic [0:0] {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;
    localparam int CNT_W = $clog2(WIDTH);

    state_t           state_q;
    logic [WIDTH-1:0] mcand_q, mplr_q, acc_q, acc_nx;
    logic [CNT_W-1:0] cnt_q;

    assign idle   = (state_q == S_IDLE);
    assign acc_nx = mplr_q[0] ? acc_q + mcand_q : acc_q;
`else
    assign idle = 1'b1;
`endif

    assign in_ready = idle && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign alu_r    = alu_op(ifun[1:0], valA, valB);

    always_comb begin
        valE_d = '0;
        cnd_d  = 1'b0;
        dst_d  = dstE_in;
        err_d  = 1'b0;
        cc_we  = 1'b0;
        cc_new = cc_q;
        mul_go = 1'b0;
        case (icode)
            I_RRMOV: begin
                valE_d = valA;
                cnd_d  = cond_eval(ifun, cc_q);
                if (!cnd_d) dst_d = 4'hF;
            end
            I_IRMOV:         valE_d = valC;
            I_RMMOV, I_MRMOV: valE_d = valB + valC;
            I_CALL, I_PUSH:  valE_d = valB - STEP;
            I_RET, I_POP:    valE_d = valB + STEP;
            I_JXX:           cnd_d  = cond_eval(ifun, cc_q);
            I_OPQ: begin
                if (ifun < 4'd4) begin
                    valE_d = alu_r[WIDTH-1:0];
                    cc_we  = !cc_block;
                    cc_new = {alu_r[WIDTH-1:0] == '0, alu_r[WIDTH-1], alu_r[WIDTH]};
`ifdef EXECUTE_UNIT_MUL_EN
                end else if (ifun == 4'd4) begin
                    mul_go = 1'b1;
`endif
                end else begin
                    err_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Result/CC registers and the IDLE/MUL sequencer share one clocked block
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            valE_q      <= '0;
            valA_out_q  <= '0;
            dstE_q      <= 4'hF;
            cnd_q       <= 1'b0;
            err_q       <= 1'b0;
            cc_q        <= 3'b100;
`ifdef EXECUTE_UNIT_MUL_EN
            state_q     <= S_IDLE;
            mcand_q     <= '0;
            mplr_q      <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
`endif
        end else begin
            if (accept) begin
                valE_q      <= valE_d;
                valA_out_q  <= valA;
                dstE_q      <= dst_d;
                cnd_q       <= cnd_d;
                err_q       <= err_d;
                out_valid_q <= !mul_go;
                if (cc_we) cc_q <= cc_new;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
`ifdef EXECUTE_UNIT_MUL_EN
            if (accept && mul_go) begin
                state_q <= S_MUL;
                mcand_q <= valB;
                mplr_q  <= valA;
                acc_q   <= '0;
                cnt_q   <= '0;
            end
            if (state_q == S_MUL) begin
                acc_q   <= acc_nx;
                mcand_q <= mcand_q << 1;
                mplr_q  <= mplr_q >> 1;
                cnt_q   <= cnt_q + 1'b1;
                // Last shift-add step: publish the product and its flags on this edge
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_q     <= S_IDLE;
                    out_valid_q <= 1'b1;
                    valE_q      <= acc_nx;
                    if (!cc_block) cc_q <= {acc_nx == '0, acc_nx[WIDTH-1], 1'b0};
                end
            end
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign valE      = valE_q;
    assign valA_out  = valA_out_q;
    assign dstE_out  = dstE_q;
    assign Cnd       = cnd_q;
    assign err       = err_q;
    assign cc        = cc_q;

endmodule

// File: tb/tb_execute_unit.sv
// Randomized self-checking bench for execute_unit (WIDTH=64) against a behavioural Y86 execute model.
module tb_execute_unit;
    localparam int W = 64;

    logic         clock = 1'b0;
    logic         reset_n;
    logic         in_valid, in_ready, cc_block, out_valid, out_ready, Cnd, err;
    logic [3:0]   icode, ifun, dstE_in, dstE_out;
    logic [W-1:0] valA, valB, valC, valE, valA_out;
    logic [2:0]   cc;

    int           n_cmp = 0;
    int           n_err = 0;
    logic [2:0]   cc_m;
    logic [W-1:0] last_valE;

    execute_unit #(.WIDTH(W)) dut (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .icode(icode), .ifun(ifun), .valA(valA), .valB(valB), .valC(valC),
        .dstE_in(dstE_in), .cc_block(cc_block), .out_valid(out_valid),
        .out_ready(out_ready), .valE(valE), .valA_out(valA_out), .dstE_out(dstE_out),
        .Cnd(Cnd), .cc(cc), .err(err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit cond_m(input logic [3:0] fn, input logic [2:0] c);
        bit zf, sf, of;
        zf = c[2]; sf = c[1]; of = c[0];
        case (fn)
            0: return 1;
            1: return (sf != of) || zf;
            2: return sf != of;
            3: return zf;
            4: return !zf;
            5: return sf == of;
            6: return (sf == of) && !zf;
            default: return 0;
        endcase
    endfunction

    // Expected results from the ISA rules; updates the model CC as the op would
    task automatic model(input logic [3:0] ic, fn, input logic [W-1:0] a, b, c,
                         input logic [3:0] d, input logic blk,
                         output logic [W-1:0] e_valE, output logic e_cnd,
                         output logic [3:0] e_dst, output logic e_err, output bit is_mul);
        logic signed [W:0] wide;
        logic [W-1:0]      r;
        logic              of;
        bit                wr;
        e_valE = '0; e_cnd = 0; e_dst = d; e_err = 0; is_mul = 0; wr = 0; of = 0; r = '0;
        case (ic)
            4'h2: begin e_valE = a; e_cnd = cond_m(fn, cc_m); if (!e_cnd) e_dst = 4'hF; end
            4'h3: e_valE = c;
            4'h4, 4'h5: e_valE = b + c;
            4'h8, 4'hA: e_valE = b - 64'd8;
            4'h9, 4'hB: e_valE = b + 64'd8;
            4'h7: e_cnd = cond_m(fn, cc_m);
            4'h6: begin
                wr = 1;
                case (fn)
                    0: begin wide = $signed({b[W-1], b}) + $signed({a[W-1], a}); r = wide[W-1:0]; of = wide[W] ^ wide[W-1]; end
                    1: begin wide = $signed({b[W-1], b}) - $signed({a[W-1], a}); r = wide[W-1:0]; of = wide[W] ^ wide[W-1]; end
                    2: r = a & b;
                    3: r = a ^ b;
`ifdef EXECUTE_UNIT_MUL_EN
                    4: begin r = a * b; is_mul = 1; end
`endif
                    default: begin wr = 0; e_err = 1; end
                endcase
                if (wr) e_valE = r;
                if (wr && !blk) cc_m = {r == '0, r[W-1], of};
            end
            default: ;
        endcase
    endtask

    task automatic do_op(input logic [3:0] ic, fn, input logic [W-1:0] a, b, c,
                         input logic [3:0] d, input logic blk);
        logic [W-1:0] e_valE;
        logic         e_cnd, e_err;
        logic [3:0]   e_dst;
        bit           is_mul;
        int           n;
        model(ic, fn, a, b, c, d, blk, e_valE, e_cnd, e_dst, e_err, is_mul);
        icode = ic; ifun = fn; valA = a; valB = b; valC = c; dstE_in = d;
        cc_block = blk; out_ready = 1'b1; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 200) begin @(posedge clock); #1; n++; end
        chk("in_ready", in_ready, 1);
        @(posedge clock); #1;
        in_valid = 1'b0;
        if (is_mul) begin
            chk("mul_busy", in_ready, 0);
            n = 0;
            while (!out_valid && n < W + 8) begin
                if (in_ready) chk("mul_in_ready", in_ready, 0);
                @(posedge clock); #1; n++;
            end
            chk("mul_latency", n, W);
        end
        chk("out_valid", out_valid, 1);
        chk("valE", valE, e_valE);
        chk("valA_out", valA_out, a);
        chk("dstE_out", dstE_out, e_dst);
        chk("Cnd", Cnd, e_cnd);
        chk("err", err, e_err);
        chk("cc", cc, cc_m);
        last_valE = e_valE;
        cc_block = 1'b0;
    endtask

    task automatic stall(input int k);
        out_ready = 1'b0;
        repeat (k) begin
            @(posedge clock); #1;
            chk("stall_valid", out_valid, 1);
            chk("stall_valE", valE, last_valE);
            chk("stall_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        #1 chk("resume_in_ready", in_ready, 1);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_Cnd"}, Cnd, 0);
        chk({tag, "_valE"}, valE, 0);
        chk({tag, "_valA_out"}, valA_out, 0);
        chk({tag, "_dstE_out"}, dstE_out, 4'hF);
        chk({tag, "_cc"}, cc, 3'b100);
        chk({tag, "_in_ready"}, in_ready, 1);
    endtask

    task automatic pulse_reset(input string tag);
        #2 reset_n = 1'b0;
        #1 check_reset_vals(tag);
        cc_m = 3'b100;
        @(negedge clock) reset_n = 1'b1;
        @(posedge clock); #1;
    endtask

    function automatic logic [W-1:0] rnd64();
        case ($urandom_range(0, 7))
            0: return 64'h0;
            1: return 64'h7FFF_FFFF_FFFF_FFFF;
            2: return 64'h8000_0000_0000_0000;
            3: return 64'hFFFF_FFFF_FFFF_FFFF;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] ic, fn;
        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; cc_block = 1'b0;
        icode = 4'h0; ifun = 4'h0; valA = '0; valB = '0; valC = '0; dstE_in = 4'hF;
        cc_m = 3'b100; last_valE = '0;
        #12 check_reset_vals("reset");
        @(negedge clock) reset_n = 1'b1;
        @(posedge clock); #1;

        do_op(4'h6, 4'h1, 64'h123, 64'h122, 64'h0, 4'h3, 1'b0);
        chk("sub_valE", valE, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("sub_cc", cc, 3'b010);
        do_op(4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'h0, 4'h4, 1'b0);
        chk("addov_valE", valE, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("addov_cc", cc, 3'b011);
        do_op(4'h7, 4'h2, 64'h0, 64'h0, 64'h40, 4'hF, 1'b0);
        chk("jl_Cnd", Cnd, 0);
        do_op(4'h6, 4'h0, 64'h1, 64'h1, 64'h0, 4'h5, 1'b0);
        do_op(4'h2, 4'h3, 64'hAA, 64'h0, 64'h0, 4'h2, 1'b0);
        chk("cmov_nt_dst", dstE_out, 4'hF);
        do_op(4'h6, 4'h3, 64'h5, 64'h5, 64'h0, 4'h6, 1'b1);
        chk("xor_blk_valE", valE, 0);
        chk("xor_blk_cc", cc, 3'b000);
        do_op(4'h6, 4'h3, 64'h5, 64'h5, 64'h0, 4'h6, 1'b0);
        do_op(4'h2, 4'h3, 64'hAA, 64'h0, 64'h0, 4'h2, 1'b0);
        chk("cmov_t_dst", dstE_out, 4'h2);
        do_op(4'h6, 4'h4, 64'h3, 64'h5, 64'h0, 4'h7, 1'b0);
`ifdef EXECUTE_UNIT_MUL_EN
        chk("mul_valE", valE, 64'd15);
`else
        chk("mul_err", err, 1);
        chk("mul_cc", cc, 3'b100);
`endif
        do_op(4'h3, 4'h0, 64'h0, 64'h0, 64'h1234, 4'h1, 1'b0);
        stall(3);
        do_op(4'hA, 4'h0, 64'h9, 64'h100, 64'h0, 4'h4, 1'b0);
        chk("push_valE", valE, 64'hF8);
        pulse_reset("midreset");

`ifdef EXECUTE_UNIT_MUL_EN
        icode = 4'h6; ifun = 4'h4; valA = 64'h7; valB = 64'h9; in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        pulse_reset("mulreset");
        repeat (W + 4) @(posedge clock);
        #1;
        chk("mulreset_out_valid", out_valid, 0);
        chk("mulreset_cc", cc, 3'b100);
`endif

        for (int i = 0; i < 400; i++) begin
            ic = 4'($urandom_range(0, 15));
            if (ic == 4'h6) fn = 4'($urandom_range(0, 7));
            else if (ic == 4'h2 || ic == 4'h7) fn = 4'($urandom_range(0, 6));
            else fn = 4'($urandom_range(0, 15));
            do_op(ic, fn, rnd64(), rnd64(), rnd64(), 4'($urandom_range(0, 15)),
                  ($urandom_range(0, 5) == 0));
            if ($urandom_range(0, 9) == 0) stall($urandom_range(1, 4));
            if ($urandom_range(0, 49) == 0) pulse_reset("rndreset");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
